// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture enable, PWM line and measured-result signals of pwm_capture
interface pwm_capture_if #(
  parameter int W = 8,
  parameter int CNT_W = 16
);
  logic i_enb;
  logic i_pwm;
  logic [W-1:0] o_duty;
  logic [CNT_W-1:0] o_period;
  logic o_valid;
  logic o_stuck;
  logic o_err;
  modport master (output i_enb, i_pwm, input o_duty, o_period, o_valid, o_stuck, o_err);
  modport slave (input i_enb, i_pwm, output o_duty, o_period, o_valid, o_stuck, o_err);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time, recovers duty with a serial divider, flags stuck lines
module pwm_capture #(
  parameter int W = 8,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1000
) (
  input logic sysclk,
  input logic i_rst,
  pwm_capture_if.slave bus
);
  localparam int CW = $clog2(W + 2);
  typedef enum logic [1:0] {S_SYNC, S_HIGH, S_LOW} state_t;
  state_t state, state_n;
  logic [2:0] sync;
  logic rise, fall, timeout, launch, restart, st_hi, st_lo, ge, busy, valid, stuck, err;
  logic [CNT_W-1:0] hi, per, den, period, rem_n;
  logic [CNT_W:0] rem;
  logic [W-1:0] q, duty;
  logic [W:0] q_full;
  logic [CW-1:0] cnt;
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  assign timeout = per == CNT_W'(TIMEOUT);
  assign ge = rem >= {1'b0, den};
  assign rem_n = ge ? CNT_W'(rem - {1'b0, den}) : rem[CNT_W-1:0];
  assign q_full = {q, ge};
  always_ff @(posedge sysclk or posedge i_rst)
    if (i_rst) sync <= '0;
    else sync <= {sync[1:0], bus.i_pwm};
  always_ff @(posedge sysclk or posedge i_rst)
    if (i_rst) state <= S_SYNC;
    else state <= state_n;
  always_comb begin
    state_n = state;
    launch = 1'b0;
    st_hi = 1'b0;
    st_lo = 1'b0;
    restart = 1'b0;
    if (!bus.i_enb) state_n = S_SYNC;
    else
      case (state)
        S_SYNC: begin
          restart = rise;
          state_n = rise ? S_HIGH : S_SYNC;
        end
        S_HIGH: begin
          st_hi = !fall && timeout;
          state_n = fall ? S_LOW : st_hi ? S_SYNC : S_HIGH;
        end
        S_LOW: begin
          launch = rise;
          restart = rise;
          st_lo = !rise && timeout;
          state_n = rise ? S_HIGH : st_lo ? S_SYNC : S_LOW;
        end
        default: state_n = S_SYNC;
      endcase
  end
  // hi counts synchronised-high cycles; per counts from one rise to the next
  always_ff @(posedge sysclk or posedge i_rst)
    if (i_rst) begin
      hi <= '0;
      per <= '0;
    end else if (!bus.i_enb || st_hi || st_lo) begin
      hi <= '0;
      per <= '0;
    end else if (restart) begin
      hi <= CNT_W'(1);
      per <= CNT_W'(1);
    end else if (state == S_HIGH) begin
      hi <= hi + CNT_W'(!fall);
      per <= per + CNT_W'(1);
    end else if (state == S_LOW) per <= per + CNT_W'(1);
  // restoring divide of {hi, W'b0} by per, one quotient bit per cycle, MSB (weight 2**W) first
  always_ff @(posedge sysclk or posedge i_rst)
    if (i_rst) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      den <= '0;
      q <= '0;
      duty <= '0;
      period <= '0;
      valid <= 1'b0;
      stuck <= 1'b0;
      err <= 1'b0;
    end else begin
      valid <= 1'b0;
      err <= 1'b0;
      if (!bus.i_enb) busy <= 1'b0;
      else begin
        if (busy) begin
          rem <= {rem_n, 1'b0};
          q <= {q[W-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy <= 1'b0;
            duty <= q_full[W] ? {W{1'b1}} : q_full[W-1:0];
            period <= den;
            valid <= 1'b1;
            stuck <= 1'b0;
          end
        end
        if (launch) begin
          if (busy) err <= 1'b1;
          else begin
            busy <= 1'b1;
            cnt <= CW'(W + 1);
            rem <= {1'b0, hi};
            den <= per;
            q <= '0;
          end
        end
        if (st_hi || st_lo) begin
          duty <= {W{st_hi}};
          period <= '0;
          valid <= 1'b1;
          stuck <= 1'b1;
        end
      end
    end
  assign bus.o_duty = duty;
  assign bus.o_period = period;
  assign bus.o_valid = valid;
  assign bus.o_stuck = stuck;
  assign bus.o_err = err;
endmodule
